fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the 512-word instruction ROM. It owns the program counter, drives the ROM address and output-enable, and registers the returned 16-bit word into an instruction register. It hands instructions to decode through a valid/ready handshake and accepts redirects from execute. With the optional feature compiled in, it also resolves unconditional jumps at fetch.

Parameters:
PC_WIDTH, 16, width of the PC and of the ROM address.
RESET_PC, 16'h0000, PC value loaded on reset.
IMEM_DEPTH, 512, number of valid ROM words; a PC at or above this value halts fetch.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
pc_output_to_imem_input  output  PC_WIDTH  ROM word address; always equals the current PC.
imem_oe  output  1  ROM output enable.
imem_output_to_rf_input  input  16  ROM read data; combinational from address/OE.
instr  output  16  registered instruction to decode.
instr_pc  output  PC_WIDTH  address the current instr was fetched from.
instr_valid  output  1  instr/instr_pc hold a live instruction.
decode_ready  input  1  decode accepts instr this cycle.
branch_taken  input  1  single-cycle redirect pulse from execute.
branch_target  input  PC_WIDTH  redirect address, sampled when branch_taken=1.
halted  output  1  fetch stopped on an out-of-range PC.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: pc=RESET_PC, instr=16'h0000, instr_pc=0, instr_valid=0, state=FETCH, halted=0.
- States:
  - FETCH: normal operation.
  - HALT: entered when pc ≥ IMEM_DEPTH in FETCH. In HALT, halted=1 and imem_oe=0.
  - HALT is left only by rst (to FETCH at RESET_PC) or by branch_taken (to FETCH at branch_target).
- Load condition: load = (state==FETCH) && (pc < IMEM_DEPTH) && !branch_taken && (!instr_valid || decode_ready).
- imem_oe = load. The ROM is tri-stated during stalls, halt and redirect.
- On load, at the clock edge:
  - instr <= imem_output_to_rf_input (X bits are passed through unchanged);
  - instr_pc <= pc;
  - instr_valid <= 1;
  - pc <= next_pc.
- next_pc = pc+1, modulo 2^PC_WIDTH. The macro below can override this.
- Latency: an address presented in cycle N produces instr in cycle N+1. Throughput is one instruction per cycle while decode_ready=1.
- Stall: instr_valid=1 and decode_ready=0 means instr, instr_pc and pc all hold.
- Drain: if an instruction is consumed (instr_valid && decode_ready) but load=0 and there is no branch, then instr_valid <= 0.
- Redirect: branch_taken=1 gives, at the next edge:
  - pc <= branch_target;
  - instr_valid <= 0, squashing any held instruction even if decode_ready=0;
  - state <= FETCH.
  - The first instruction from the target appears two cycles after the pulse.
- Priority: rst > branch_taken > stall > jump > increment.
- The halt check uses the current pc before any load. Entering HALT does not clear a held valid instruction; it drains normally.

Optional Feature:
FETCH_EARLY_JMP_EN
- Defined: when a loaded word has opcode [15:12]==4'b1110, next_pc = zero-extended [11:0] instead of pc+1. This is a zero-bubble jump.
  - The jmp word is still delivered to decode with instr_valid=1.
  - Execute must not raise branch_taken for jmp.
  - Only bits [15:12] are inspected for this decode.
- Undefined: jmp is treated like any other word (pc+1). Execute must redirect with branch_taken.

Test Plan:
1. Reset, then decode_ready=1 with the ROM holding words W0..W3:
   - instr = W0, W1, W2, W3 on cycles 1–4 after reset release;
   - instr_pc = 0, 1, 2, 3;
   - imem_oe=1 throughout.
2. Stall: drop decode_ready for 3 cycles while instr_pc=2.
   - instr holds W2, pc holds 3, imem_oe=0.
   - On release, W3 and then W4 follow on consecutive cycles.
3. Jump: ROM word 9 = 16'hE004.
   - Macro defined: the instr following E004 has instr_pc=4.
   - Macro undefined: the following instr_pc=10.
   - Then pulse branch_taken with target 4: instr_valid=0 for one cycle, then instr_pc=4.
4. Redirect under back-pressure: instr_valid=1, decode_ready=0, branch_taken with target 16'h000B.
   - instr_valid=0 on the next cycle.
   - One cycle later, instr=ROM[11] with instr_pc=11.
5. Halt: run sequentially to pc=511.
   - ROM[511] is delivered.
   - Then halted=1, imem_oe=0, and instr_valid falls once ROM[511] is consumed.
   - branch_taken with target 0 restarts fetch: instr_pc=0 two cycles later, halted=0.
6. Reset mid-stall: assert rst with instr_valid=1 and decode_ready=0.
   - Next cycle: instr_valid=0, pc=RESET_PC, halted=0.
   - ROM[0] is delivered one cycle after rst deasserts.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives the 512-word instruction ROM.
// It registers each returned word into an instruction register and hands it to
// decode over a valid/ready handshake. Redirects from execute override everything
// except reset. A PC at or above IMEM_DEPTH parks the unit in HALT.
// Optional build macro FETCH_EARLY_JMP_EN: a fetched word with opcode 4'b1110
// sets the next PC to its zero-extended [11:0] field (a zero-bubble jump).
module fetch_unit #(
  parameter int unsigned         PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         IMEM_DEPTH = 512
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] pc_output_to_imem_input,
  output logic                imem_oe,
  input  logic [15:0]         imem_output_to_rf_input,
  output logic [15:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                decode_ready,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                halted
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  localparam logic [PC_WIDTH:0] DEPTH_EXT = (PC_WIDTH+1)'(IMEM_DEPTH);
  localparam logic [3:0]        OP_JMP    = 4'b1110;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_p0_q;
  logic [15:0]         instr_p1_q;
  logic [PC_WIDTH-1:0] instr_pc_p1_q;
  logic                vld_p1_q;

  logic                in_range_p0;
  logic                load_p0;
  logic [PC_WIDTH-1:0] next_pc_p0_d;

  // Fetch decision for this cycle: range check on the current PC, load gating and next PC.
  always_comb begin
    in_range_p0  = ({1'b0, pc_p0_q} < DEPTH_EXT);
    load_p0      = (state_q == S_FETCH) && in_range_p0 && !branch_taken &&
                   (!vld_p1_q || decode_ready);
    next_pc_p0_d = pc_p0_q + PC_WIDTH'(1);
`ifdef FETCH_EARLY_JMP_EN
    // Only the opcode nibble is decoded; the target is the raw 12-bit field.
    if (imem_output_to_rf_input[15:12] == OP_JMP) begin
      next_pc_p0_d = PC_WIDTH'(imem_output_to_rf_input[11:0]);
    end
`endif
  end

  // PC, instruction register and FSM; priority is reset, redirect, stall/load, drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_p0_q       <= RESET_PC;
      instr_p1_q    <= 16'h0000;
      instr_pc_p1_q <= '0;
      vld_p1_q      <= 1'b0;
    end else if (branch_taken) begin
      // Redirect squashes any held instruction, even under back-pressure.
      state_q  <= S_FETCH;
      pc_p0_q  <= branch_target;
      vld_p1_q <= 1'b0;
    end else begin
      // ---- p0 -> p1: ROM word captured into the instruction register ----
      if (load_p0) begin
        instr_p1_q    <= imem_output_to_rf_input;
        instr_pc_p1_q <= pc_p0_q;
        vld_p1_q      <= 1'b1;
        pc_p0_q       <= next_pc_p0_d;
      end else if (vld_p1_q && decode_ready) begin
        vld_p1_q <= 1'b0;
      end
      // A held instruction is not cleared on halt entry; it drains above.
      if ((state_q == S_FETCH) && !in_range_p0) begin
        state_q <= S_HALT;
      end
    end
  end

  assign pc_output_to_imem_input = pc_p0_q;
  assign imem_oe                 = load_p0;
  assign instr                   = instr_p1_q;
  assign instr_pc                = instr_pc_p1_q;
  assign instr_valid             = vld_p1_q;
  assign halted                  = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table for the main
// flows plus hand-written sequences for the long sequential run, halt and
// reset-under-stall cases. ROM word i holds 16'h1000+i, except word 9 = 16'hE004.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        imem_oe;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halted;

  logic [15:0] rom [0:511];

  int n_vec = 0;
  int n_bad = 0;

`ifdef FETCH_EARLY_JMP_EN
  localparam logic [15:0] J_PC = 16'd4;
`else
  localparam logic [15:0] J_PC = 16'd10;
`endif

  fetch_unit #(
    .PC_WIDTH  (16),
    .RESET_PC  (16'h0000),
    .IMEM_DEPTH(512)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .pc_output_to_imem_input(pc),
    .imem_oe                (imem_oe),
    .imem_output_to_rf_input(imem_data),
    .instr                  (instr),
    .instr_pc               (instr_pc),
    .instr_valid            (instr_valid),
    .decode_ready           (decode_ready),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .halted                 (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    imem_data = 16'h0000;
    if (imem_oe && (pc < 16'd512)) imem_data = rom[pc[8:0]];
  end

  typedef struct {
    logic        r;
    logic        rdy;
    logic        bt;
    logic [15:0] tgt;
    logic        oe;
    logic        v;
    logic [15:0] ipc;
    logic [15:0] ins;
    logic [15:0] npc;
    logic        h;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] w(input int i);
    return (i == 9) ? 16'hE004 : (16'h1000 + 16'(i));
  endfunction

  // One clock: drive inputs at negedge, sample imem_oe before the edge, then
  // registered outputs 1 time unit after the edge. instr/instr_pc are ignored
  // when the expected valid is 0.
  task automatic step(input string nm, input vec_t t);
    logic        oe_s;
    logic [50:0] act, exp;
    @(negedge clk);
    rst           = t.r;
    decode_ready  = t.rdy;
    branch_taken  = t.bt;
    branch_target = t.tgt;
    #1;
    oe_s = imem_oe;
    @(posedge clk);
    #1;
    act = {oe_s, instr_valid, t.v ? instr_pc : 16'h0, t.v ? instr : 16'h0, pc, halted};
    exp = {t.oe, t.v, t.v ? t.ipc : 16'h0, t.v ? t.ins : 16'h0, t.npc, t.h};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got oe=%b v=%b ipc=%h ins=%h pc=%h h=%b, want oe=%b v=%b ipc=%h ins=%h pc=%h h=%b",
               nm, oe_s, instr_valid, instr_pc, instr, pc, halted,
               t.oe, t.v, t.ipc, t.ins, t.npc, t.h);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = w(i);

    rst = 1'b1; decode_ready = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    @(posedge clk);

    //               r    rdy  bt   tgt      oe   v    ipc      ins        pc       h
    tbl.push_back('{1'b1,1'b0,1'b0,16'h0,   1'b1,1'b0,16'd0,   16'h0000,  16'd0,   1'b0}); // reset state
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd0,   w(0),      16'd1,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd1,   w(1),      16'd2,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd2,   w(2),      16'd3,   1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0,   1'b0,1'b1,16'd2,   w(2),      16'd3,   1'b0}); // stall x3
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0,   1'b0,1'b1,16'd2,   w(2),      16'd3,   1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0,   1'b0,1'b1,16'd2,   w(2),      16'd3,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd3,   w(3),      16'd4,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd4,   w(4),      16'd5,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd5,   w(5),      16'd6,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd6,   w(6),      16'd7,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd7,   w(7),      16'd8,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd8,   w(8),      16'd9,   1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd9,   16'hE004,  J_PC,    1'b0}); // jmp word
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,J_PC,    w(int'(J_PC)), J_PC+16'd1, 1'b0});
    tbl.push_back('{1'b0,1'b1,1'b1,16'd4,   1'b0,1'b0,16'd0,   16'h0000,  16'd4,   1'b0}); // redirect
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd4,   w(4),      16'd5,   1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0,   1'b0,1'b1,16'd4,   w(4),      16'd5,   1'b0}); // held
    tbl.push_back('{1'b0,1'b0,1'b1,16'h000B,1'b0,1'b0,16'd0,   16'h0000,  16'd11,  1'b0}); // squash
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0,   1'b1,1'b1,16'd11,  w(11),     16'd12,  1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b0,1'b1,16'd11,  w(11),     16'd12,  1'b0}); // vld=1: oe gated? see note
    tbl.pop_back();
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0,   1'b1,1'b1,16'd12,  w(12),     16'd13,  1'b0});

    foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k]);

    // Sequential run from 13 up to the last ROM word.
    for (int i = 13; i < 512; i++)
      step($sformatf("seq%0d", i), '{1'b0,1'b1,1'b0,16'h0, 1'b1,1'b1,16'(i),w(i),16'(i+1),1'b0});

    // Halt: ROM[511] held, fetch stops, then drains.
    step("halt_hold",  '{1'b0,1'b0,1'b0,16'h0, 1'b0,1'b1,16'd511,w(511),16'd512,1'b1});
    step("halt_drain", '{1'b0,1'b1,1'b0,16'h0, 1'b0,1'b0,16'd0,16'h0,16'd512,1'b1});
    step("halt_stay",  '{1'b0,1'b1,1'b0,16'h0, 1'b0,1'b0,16'd0,16'h0,16'd512,1'b1});
    step("halt_exit",  '{1'b0,1'b1,1'b1,16'h0, 1'b0,1'b0,16'd0,16'h0,16'd0,1'b0});
    step("restart",    '{1'b0,1'b1,1'b0,16'h0, 1'b1,1'b1,16'd0,w(0),16'd1,1'b0});

    // Reset while a stalled instruction is held.
    step("stall_pre",  '{1'b0,1'b0,1'b0,16'h0, 1'b0,1'b1,16'd0,w(0),16'd1,1'b0});
    step("rst_stall",  '{1'b1,1'b0,1'b0,16'h0, 1'b0,1'b0,16'd0,16'h0,16'd0,1'b0});
    step("post_rst",   '{1'b0,1'b0,1'b0,16'h0, 1'b1,1'b1,16'd0,w(0),16'd1,1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
